// File: rtl/regfile_scoreboard_if.sv
// Operand/writeback/issue bundle for the ID-stage register file with load-use scoreboard.
// The master side is the pipeline; the slave side is the register file.
interface regfile_scoreboard_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned DBG_W  = 16
) ();

  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;

  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;

  logic                     issue_valid;
  logic                     issue_pend;
  logic [ADDR_W-1:0]        issue_dst;

  logic [NUM_RD-1:0]        hazard;
  logic                     stall;
  logic [2**ADDR_W-1:0]     pending;
  logic [DBG_W-1:0]         debug_leds;

  modport master (
    output rd_en, rd_addr,
    output wr_en, wr_addr, wr_data,
    output issue_valid, issue_pend, issue_dst,
    input  rd_data, hazard, stall, pending, debug_leds
  );

  modport slave (
    input  rd_en, rd_addr,
    input  wr_en, wr_addr, wr_data,
    input  issue_valid, issue_pend, issue_dst,
    output rd_data, hazard, stall, pending, debug_leds
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with same-cycle write bypass, per-register pending
// scoreboard for in-flight loads, load-use stall generation and a debug tap.
module regfile_scoreboard #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned DBG_REG = 8,
  parameter int unsigned DBG_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_scoreboard_if.slave   bus
);

  localparam int unsigned NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] DBG_IDX = ADDR_W'(DBG_REG);

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regfile_scoreboard: NUM_RD must be in 1..4");
  end
  if (DBG_W > DATA_W || DBG_W < 1) begin : g_bad_dbg_w
    $error("regfile_scoreboard: DBG_W must be in 1..DATA_W");
  end
  if (DBG_REG >= NREG) begin : g_bad_dbg_reg
    $error("regfile_scoreboard: DBG_REG out of register range");
  end

  logic [DATA_W-1:0]        regs_q [NREG];
  logic [NREG-1:0]          pending_q;
  logic [NREG-1:0]          pending_d;
  logic [DBG_W-1:0]         debug_q;
  logic [DBG_W-1:0]         debug_d;

  logic                     wr_commit;
  logic                     issue_accept;
  logic [NUM_RD*DATA_W-1:0] rd_data_w;
  logic [NUM_RD-1:0]        hazard_w;
  logic                     stall_w;
  logic [ADDR_W-1:0]        raddr;

  assign wr_commit = bus.wr_en && (bus.wr_addr != '0);

  // Read ports: reads of r0 and reads during reset return zero; a retiring
  // WB write to the same register is forwarded and also resolves the hazard.
  always_comb begin
    rd_data_w = '0;
    hazard_w  = '0;
    raddr     = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      raddr = bus.rd_addr[p*ADDR_W +: ADDR_W];
      if (rst_n && (raddr != '0)) begin
        if (wr_commit && (bus.wr_addr == raddr)) begin
          rd_data_w[p*DATA_W +: DATA_W] = bus.wr_data;
        end else begin
          rd_data_w[p*DATA_W +: DATA_W] = regs_q[raddr];
          hazard_w[p] = bus.rd_en[p] && pending_q[raddr];
        end
      end
    end
  end

  assign stall_w      = |hazard_w;
  assign issue_accept = bus.issue_valid && bus.issue_pend &&
                        (bus.issue_dst != '0) && !stall_w;

  // Set is applied after clear so a new load to the retiring register wins.
  always_comb begin
    pending_d = pending_q;
    if (wr_commit) begin
      pending_d[bus.wr_addr] = 1'b0;
    end
    if (issue_accept) begin
      pending_d[bus.issue_dst] = 1'b1;
    end
  end

  always_comb begin
    debug_d = regs_q[DBG_IDX][DBG_W-1:0];
    if (wr_commit && (bus.wr_addr == DBG_IDX)) begin
      debug_d = bus.wr_data[DBG_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_commit) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      debug_q   <= '0;
    end else begin
      pending_q <= pending_d;
      debug_q   <= debug_d;
    end
  end

  assign bus.rd_data    = rd_data_w;
  assign bus.hazard     = hazard_w;
  assign bus.stall      = stall_w;
  assign bus.pending    = pending_q;
  assign bus.debug_leds = debug_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: stimulus pushes expected outputs from
// a behavioural register-file model; a negedge monitor pops and compares.
module tb_regfile_scoreboard;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 2;
  localparam int NREG = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .DBG_W(16)) bus ();

  regfile_scoreboard #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .DBG_REG(8), .DBG_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0]  sel;   // 0 rd_data, 1 hazard, 2 stall, 3 pending, 4 debug_leds
    logic [1:0]  port;
    logic [31:0] val;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    passes = 0;

  logic [31:0] m_reg [NREG];
  bit          m_pend [NREG];
  logic [15:0] m_dbg;
  bit          m_stall;

  task automatic push(input string t, input int s, input int p, input logic [31:0] v);
    exp_t e;
    e.sel  = 3'(s);
    e.port = 2'(p);
    e.val  = v;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_reg[r]  = '0;
      m_pend[r] = 1'b0;
    end
    m_dbg = '0;
  endtask

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    v = '0;
    for (int r = 0; r < NREG; r++) v[r] = m_pend[r];
    return v;
  endfunction

  // Expected combinational and registered outputs for the current inputs.
  task automatic push_model();
    logic [AW-1:0] a;
    logic [31:0]   d;
    bit            h, byp;
    m_stall = 1'b0;
    for (int p = 0; p < NR; p++) begin
      a   = bus.rd_addr[p*AW +: AW];
      byp = bus.wr_en && (bus.wr_addr == a);
      d   = 32'h0;
      h   = 1'b0;
      if (rst_n && a != 0) begin
        d = byp ? bus.wr_data : m_reg[a];
        h = bus.rd_en[p] && m_pend[a] && !byp;
      end
      m_stall = m_stall | h;
      push($sformatf("rd_data[%0d] a=%0d", p, a), 0, p, d);
      push($sformatf("hazard[%0d] a=%0d", p, a), 1, p, {31'h0, h});
    end
    push("stall", 2, 0, {31'h0, m_stall});
    push("pending", 3, 0, pend_vec());
    push("debug_leds", 4, 0, {16'h0, m_dbg});
  endtask

  // One cycle: expectations for this cycle, clock edge, then model update.
  task automatic tick();
    bit            rn, we, iv, ip, st;
    logic [AW-1:0] wa, dst;
    logic [31:0]   wd;
    push_model();
    rn = rst_n; we = bus.wr_en; wa = bus.wr_addr; wd = bus.wr_data;
    iv = bus.issue_valid; ip = bus.issue_pend; dst = bus.issue_dst; st = m_stall;
    @(posedge clk);
    if (rn) begin
      if (we && wa != 0) begin
        m_reg[wa]  = wd;
        m_pend[wa] = 1'b0;
      end
      if (iv && ip && dst != 0 && !st) m_pend[dst] = 1'b1;
      m_dbg = m_reg[8][15:0];
    end
    #1;
  endtask

  task automatic idle();
    bus.rd_en = '0; bus.rd_addr = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.issue_valid = 1'b0; bus.issue_pend = 1'b0; bus.issue_dst = '0;
  endtask

  task automatic set_rd(input int p, input bit en, input int a);
    bus.rd_en[p] = en;
    bus.rd_addr[p*AW +: AW] = AW'(a);
  endtask

  always @(negedge clk) begin
    exp_t        e;
    string       t;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      case (e.sel)
        3'd0:    act = bus.rd_data[e.port*DW +: DW];
        3'd1:    act = {31'h0, bus.hazard[e.port]};
        3'd2:    act = {31'h0, bus.stall};
        3'd3:    act = bus.pending;
        default: act = {16'h0, bus.debug_leds};
      endcase
      checks++;
      if (act === e.val) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", t, act, e.val, $time);
    end
  end

  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hDEAD_BEEF;
    set_rd(0, 1'b1, 3);
    push("reset_rd_bypass_blocked", 0, 0, 32'h0);
    tick();
    idle();
    rst_n = 1'b1;

    for (int a = 0; a < NREG; a++) begin
      set_rd(0, 1'b0, a);
      set_rd(1, 1'b0, NREG - 1 - a);
      tick();
    end

    bus.wr_en = 1'b1; bus.wr_addr = 5'd8; bus.wr_data = 32'h1234_ABCD;
    tick();
    idle();
    set_rd(0, 1'b0, 8);
    push("r8_read", 0, 0, 32'h1234_ABCD);
    push("dbg_r8", 4, 0, 32'h0000_ABCD);
    tick();

    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFF_FFFF;
    bus.issue_valid = 1'b1; bus.issue_pend = 1'b1; bus.issue_dst = 5'd0;
    set_rd(0, 1'b1, 0); set_rd(1, 1'b1, 0);
    push("r0_bypass", 0, 0, 32'h0);
    tick();
    idle();
    set_rd(0, 1'b1, 0);
    push("r0_after", 0, 0, 32'h0);
    push("pend_r0", 3, 0, 32'h0);
    tick();

    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'h55;
    set_rd(0, 1'b0, 5); set_rd(1, 1'b0, 5);
    push("r5_bypass_p0", 0, 0, 32'h55);
    push("r5_bypass_p1", 0, 1, 32'h55);
    tick();
    idle();

    bus.issue_valid = 1'b1; bus.issue_pend = 1'b1; bus.issue_dst = 5'd9;
    tick();
    idle();
    set_rd(0, 1'b1, 9);
    push("hazard_r9", 1, 0, 32'h1);
    push("stall_r9", 2, 0, 32'h1);
    tick();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h77;
    push("hazard_r9_wb", 1, 0, 32'h0);
    push("rd_r9_wb", 0, 0, 32'h77);
    push("stall_r9_wb", 2, 0, 32'h0);
    tick();
    idle();
    push("pend_r9_clear", 3, 0, 32'h0);
    tick();

    bus.issue_valid = 1'b1; bus.issue_pend = 1'b1; bus.issue_dst = 5'd3;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h10;
    tick();
    idle();
    set_rd(1, 1'b0, 3);
    push("pend_r3_set_wins", 3, 0, 32'h0000_0008);
    push("r3_written", 0, 1, 32'h10);
    tick();

    bus.issue_valid = 1'b1; bus.issue_pend = 1'b1; bus.issue_dst = 5'd4;
    tick();
    bus.issue_dst = 5'd7;
    tick();
    idle();
    set_rd(0, 1'b1, 4);
    push("hazard_r4", 1, 0, 32'h1);
    tick();
    set_rd(0, 1'b1, 4);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'hCAFE;
    rst_n = 1'b0;
    model_reset();
    push("rst_pending", 3, 0, 32'h0);
    push("rst_stall", 2, 0, 32'h0);
    push("rst_rd", 0, 0, 32'h0);
    tick();
    idle();
    rst_n = 1'b1;
    set_rd(0, 1'b0, 4);
    push("no_commit_in_reset", 0, 0, 32'h0);
    tick();

    for (int c = 0; c < 600; c++) begin
      bus.wr_en       = ($urandom_range(0, 2) != 0);
      bus.wr_addr     = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 9));
      bus.wr_data     = $urandom;
      bus.issue_valid = ($urandom_range(0, 1) != 0);
      bus.issue_pend  = ($urandom_range(0, 1) != 0);
      bus.issue_dst   = AW'($urandom_range(0, 9));
      for (int p = 0; p < NR; p++) begin
        set_rd(p, ($urandom_range(0, 3) != 0), (($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 9)));
      end
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d pending expectations expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
